// File: rtl/video_sprite_bounce.sv
// video_sprite_bounce
//   Pixel generator for the HDMI path. It draws a blue border and a white
//   background, and shows a ROM-backed RGB565 sprite that bounces inside the
//   border. The sprite moves by STEP pixels once every MOVE_DIV frames. The
//   pause input freezes the motion. When KEY_EN is set, ROM words equal to
//   KEY_565 are transparent and show the background.
//   The output latency is ROM_LAT+2 cycles from pixel_xpos/ypos to pixel_data.
// Ports
//   pixel_clk, sys_rst_n     : pixel clock; asynchronous active-low reset
//   pixel_xpos, pixel_ypos   : current raster position from the timing generator
//   pause                    : 1 freezes motion and the frame divider
//   rom_addr / rom_rd_data   : registered sprite ROM address; the RGB565 word
//                              returns ROM_LAT cycles later
//   pixel_data               : RGB888 pixel to the TMDS encoder
//   block_x, block_y         : current sprite origin
//   hit_h, hit_v             : one-cycle pulse on a horizontal / vertical bounce
module video_sprite_bounce #(
  parameter int          H_DISP   = 1280,
  parameter int          V_DISP   = 720,
  parameter int          SIDE_W   = 40,
  parameter int          SPR_W    = 100,
  parameter int          SPR_H    = 100,
  parameter int          STEP     = 1,
  parameter int          MOVE_DIV = 1,
  parameter int          ROM_LAT  = 1,
  parameter int          ADDR_W   = 14,
  parameter bit          KEY_EN   = 1'b1,
  parameter logic [15:0] KEY_565  = 16'h0000
) (
  input  logic              pixel_clk,
  input  logic              sys_rst_n,
  input  logic [10:0]       pixel_xpos,
  input  logic [10:0]       pixel_ypos,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_rd_data,
  output logic [23:0]       pixel_data,
  output logic [10:0]       block_x,
  output logic [10:0]       block_y,
  output logic              hit_h,
  output logic              hit_v
);

  localparam logic [11:0] SIDE_12  = 12'(SIDE_W);
  localparam logic [11:0] STEP_12  = 12'(STEP);
  localparam logic [11:0] X_MAX    = 12'(H_DISP - SIDE_W - SPR_W);
  localparam logic [11:0] Y_MAX    = 12'(V_DISP - SIDE_W - SPR_H);
  localparam logic [11:0] RIGHT_B  = 12'(H_DISP - SIDE_W);
  localparam logic [11:0] BOTTOM_B = 12'(V_DISP - SIDE_W);
  localparam logic [11:0] SPR_W12  = 12'(SPR_W);
  localparam logic [11:0] SPR_H12  = 12'(SPR_H);
  localparam logic [15:0] DIV_LAST = 16'(MOVE_DIV - 1);
  localparam int          PROD_W   = ADDR_W + 11;

  // One axis of the bounce. Returns {hit, moving_negative, new_position}.
  function automatic logic [12:0] axis_step(input logic [10:0] pos,
                                            input logic        go_neg,
                                            input logic [11:0] hi);
    logic [11:0] pos12;
    pos12 = {1'b0, pos};
    if (!go_neg) begin
      if (pos12 + STEP_12 >= hi) axis_step = {1'b1, 1'b1, hi[10:0]};
      else                       axis_step = {1'b0, 1'b0, pos + STEP_12[10:0]};
    end else begin
      if (pos12 <= SIDE_12 + STEP_12) axis_step = {1'b1, 1'b0, SIDE_12[10:0]};
      else                            axis_step = {1'b0, 1'b1, pos - STEP_12[10:0]};
    end
  endfunction

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] w);
    return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
  endfunction

  logic [10:0]        block_x_q, block_x_d, block_y_q, block_y_d;
  logic               h_left_q, h_left_d, v_up_q, v_up_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               origin_q, origin_d;
  logic               hit_h_q, hit_h_d, hit_v_q, hit_v_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               border_p1_q, border_p1_d, spr_p1_q, spr_p1_d;
  logic [ROM_LAT-1:0] border_dly_q, border_dly_d, spr_dly_q, spr_dly_d;
  logic [23:0]        pixel_data_q, pixel_data_d;

  logic        at_origin, frame_tick, move_evt;
  logic [12:0] x_step, y_step;
  logic [11:0] x12, y12, bx12, by12;
  logic [10:0] dx, dy;
  logic        in_border, in_sprite;

  // Motion: the position only changes on a frame tick, so a frame never tears.
  always_comb begin
    at_origin   = (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
    frame_tick  = at_origin && !origin_q;
    move_evt    = frame_tick && !pause && (frame_cnt_q == DIV_LAST);
    origin_d    = at_origin;
    frame_cnt_d = frame_cnt_q;
    if (frame_tick && !pause)
      frame_cnt_d = (frame_cnt_q == DIV_LAST) ? 16'd0 : frame_cnt_q + 16'd1;
    x_step    = axis_step(block_x_q, h_left_q, X_MAX);
    y_step    = axis_step(block_y_q, v_up_q, Y_MAX);
    block_x_d = block_x_q;
    block_y_d = block_y_q;
    h_left_d  = h_left_q;
    v_up_d    = v_up_q;
    hit_h_d   = 1'b0;
    hit_v_d   = 1'b0;
    if (move_evt) begin
      {hit_h_d, h_left_d, block_x_d} = x_step;
      {hit_v_d, v_up_d, block_y_d}   = y_step;
    end
  end

  // Stage p0 -> p1: region decode and the ROM address.
  always_comb begin
    x12  = {1'b0, pixel_xpos};
    y12  = {1'b0, pixel_ypos};
    bx12 = {1'b0, block_x_q};
    by12 = {1'b0, block_y_q};
    dx   = pixel_xpos - block_x_q;
    dy   = pixel_ypos - block_y_q;
    in_border = (x12 < SIDE_12) || (x12 >= RIGHT_B) ||
                (y12 < SIDE_12) || (y12 >= BOTTOM_B);
    in_sprite = (x12 >= bx12) && (x12 < bx12 + SPR_W12) &&
                (y12 >= by12) && (y12 < by12 + SPR_H12);
    rom_addr_d  = in_sprite ?
                  ADDR_W'(PROD_W'(dy) * PROD_W'(SPR_W) + PROD_W'(dx)) : '0;
    border_p1_d = in_border;
    spr_p1_d    = in_sprite;
    // Stage p1 -> p1+ROM_LAT: the flags wait for the ROM word. The oldest flag is in the MSB.
    border_dly_d = ROM_LAT'({border_dly_q, border_p1_q});
    spr_dly_d    = ROM_LAT'({spr_dly_q, spr_p1_q});
    // Output stage: the border wins, then an opaque sprite word, then the background.
    if (border_dly_q[ROM_LAT-1])
      pixel_data_d = 24'h0000FF;
    else if (spr_dly_q[ROM_LAT-1] && !(KEY_EN && (rom_rd_data == KEY_565)))
      pixel_data_d = rgb565_to_888(rom_rd_data);
    else
      pixel_data_d = 24'hFFFFFF;
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      block_x_q    <= SIDE_12[10:0];
      block_y_q    <= SIDE_12[10:0];
      h_left_q     <= 1'b0;
      v_up_q       <= 1'b0;
      frame_cnt_q  <= 16'd0;
      origin_q     <= 1'b0;
      hit_h_q      <= 1'b0;
      hit_v_q      <= 1'b0;
      rom_addr_q   <= '0;
      border_p1_q  <= 1'b0;
      spr_p1_q     <= 1'b0;
      border_dly_q <= '0;
      spr_dly_q    <= '0;
      pixel_data_q <= 24'd0;
    end else begin
      block_x_q    <= block_x_d;
      block_y_q    <= block_y_d;
      h_left_q     <= h_left_d;
      v_up_q       <= v_up_d;
      frame_cnt_q  <= frame_cnt_d;
      origin_q     <= origin_d;
      hit_h_q      <= hit_h_d;
      hit_v_q      <= hit_v_d;
      rom_addr_q   <= rom_addr_d;
      border_p1_q  <= border_p1_d;
      spr_p1_q     <= spr_p1_d;
      border_dly_q <= border_dly_d;
      spr_dly_q    <= spr_dly_d;
      pixel_data_q <= pixel_data_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign pixel_data = pixel_data_q;
  assign block_x    = block_x_q;
  assign block_y    = block_y_q;
  assign hit_h      = hit_h_q;
  assign hit_v      = hit_v_q;

endmodule

// File: tb/tb_video_sprite_bounce.sv
// Bench for video_sprite_bounce with STEP=7, MOVE_DIV=3 and ROM_LAT=1.
// A reference model derives every output from the screen geometry and the
// bounce rules. A negedge process compares the DUT with the model on every
// cycle. Directed checks pin literal values.
module tb_video_sprite_bounce;
  localparam int SW = 40, XMAX = 1140, YMAX = 580, STP = 7, DIV = 3;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] xpos, ypos;
  logic        pause;
  logic [13:0] rom_addr;
  logic [15:0] rom_rd_data = 16'h0;
  logic [23:0] pixel_data;
  logic [10:0] block_x, block_y;
  logic        hit_h, hit_v;

  video_sprite_bounce #(.STEP(STP), .MOVE_DIV(DIV), .ROM_LAT(1), .ADDR_W(14),
                        .KEY_EN(1'b1), .KEY_565(16'h0000)) dut (
    .pixel_clk(clk), .sys_rst_n(rst_n), .pixel_xpos(xpos), .pixel_ypos(ypos),
    .pause(pause), .rom_addr(rom_addr), .rom_rd_data(rom_rd_data),
    .pixel_data(pixel_data), .block_x(block_x), .block_y(block_y),
    .hit_h(hit_h), .hit_v(hit_v));

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_fn(input int a);
    case (a)
      0:       return 16'h0000;
      1:       return 16'h07E0;
      100:     return 16'h8410;
      9999:    return 16'hF800;
      default: return 16'(a * 40503 + 12345);
    endcase
  endfunction

  // ROM with one cycle of read latency.
  always @(posedge clk) rom_rd_data <= rom_fn(int'(rom_addr));

  function automatic logic [23:0] expand(input logic [15:0] w);
    int r, g, b;
    r = (int'(w) >> 11) & 31;
    g = (int'(w) >> 5) & 63;
    b = int'(w) & 31;
    return 24'((r * 8 + r / 4) * 65536 + (g * 4 + g / 16) * 256 + (b * 8 + b / 4));
  endfunction

  int cyc = 0, n_cmp = 0, n_bad = 0;
  logic [23:0] exp_pix [DEPTH];
  int          exp_addr[DEPTH], exp_bx[DEPTH], exp_by[DEPTH];
  logic        exp_hh[DEPTH], exp_hv[DEPTH], exp_vld[DEPTH];
  logic [23:0] obs_pix [DEPTH];
  int          obs_addr[DEPTH], obs_bx[DEPTH], obs_by[DEPTH];
  logic        obs_hh[DEPTH], obs_hv[DEPTH];

  int mx = SW, my = SW, mfc = 0;
  bit mleft = 0, mup = 0, mprev = 0;

  initial for (int i = 0; i < DEPTH; i++) exp_vld[i] = 1'b0;

  // Reference model: evaluates the inputs of cycle cyc before the next edge.
  task automatic model_eval();
    int x, y, addr;
    bit border, spr, tick, hh, hv;
    logic [15:0] w;
    if (cyc + 4 >= DEPTH) begin
      $display("FAIL cycle_budget got=%0d want<%0d", cyc, DEPTH - 4);
      $fatal(1);
    end
    if (!rst_n) begin
      mx = SW; my = SW; mleft = 0; mup = 0; mfc = 0; mprev = 0;
      exp_addr[cyc+1] = 0; exp_bx[cyc+1] = SW; exp_by[cyc+1] = SW;
      exp_hh[cyc+1] = 0; exp_hv[cyc+1] = 0; exp_vld[cyc+1] = 1;
      exp_pix[cyc+1] = 24'h0; exp_pix[cyc+2] = 24'hFFFFFF; exp_pix[cyc+3] = 24'hFFFFFF;
      return;
    end
    x = int'(xpos); y = int'(ypos);
    border = x < SW || x >= 1280 - SW || y < SW || y >= 720 - SW;
    spr = x >= mx && x < mx + 100 && y >= my && y < my + 100;
    addr = spr ? (y - my) * 100 + (x - mx) : 0;
    w = rom_fn(addr);
    exp_addr[cyc+1] = addr;
    exp_pix[cyc+3] = border ? 24'h0000FF : (spr && w != 16'h0) ? expand(w) : 24'hFFFFFF;
    tick = (x == 0 && y == 0) && !mprev;
    mprev = (x == 0 && y == 0);
    hh = 0; hv = 0;
    if (tick && !pause) begin
      if (mfc == DIV - 1) begin
        mfc = 0;
        if (!mleft) begin
          if (mx + STP >= XMAX) begin mx = XMAX; mleft = 1; hh = 1; end else mx += STP;
        end else begin
          if (mx <= SW + STP) begin mx = SW; mleft = 0; hh = 1; end else mx -= STP;
        end
        if (!mup) begin
          if (my + STP >= YMAX) begin my = YMAX; mup = 1; hv = 1; end else my += STP;
        end else begin
          if (my <= SW + STP) begin my = SW; mup = 0; hv = 1; end else my -= STP;
        end
      end else mfc++;
    end
    exp_bx[cyc+1] = mx; exp_by[cyc+1] = my;
    exp_hh[cyc+1] = hh; exp_hv[cyc+1] = hv; exp_vld[cyc+1] = 1;
  endtask

  task automatic cyc_drive(input int x, input int y, input bit p);
    xpos = 11'(x); ypos = 11'(y); pause = p;
    model_eval();
    @(posedge clk);
    cyc++;
    #1;
    obs_pix[cyc] = pixel_data; obs_addr[cyc] = int'(rom_addr);
    obs_bx[cyc] = int'(block_x); obs_by[cyc] = int'(block_y);
    obs_hh[cyc] = hit_h; obs_hv[cyc] = hit_v;
    @(negedge clk);
  endtask

  task automatic frame(input bit p);
    cyc_drive(1, 0, p);
    cyc_drive(0, 0, p);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  // Compares the DUT with the model on every cycle.
  always @(negedge clk) begin
    if (cyc > 0 && cyc < DEPTH && exp_vld[cyc]) begin
      n_cmp++;
      if (pixel_data !== exp_pix[cyc] || int'(rom_addr) != exp_addr[cyc] ||
          $isunknown(rom_addr) || int'(block_x) != exp_bx[cyc] ||
          int'(block_y) != exp_by[cyc] || hit_h !== exp_hh[cyc] || hit_v !== exp_hv[cyc]) begin
        n_bad++;
        $display("FAIL model_cyc%0d got pix=%h addr=%0d bx=%0d by=%0d hh=%b hv=%b want pix=%h addr=%0d bx=%0d by=%0d hh=%b hv=%b",
                 cyc, pixel_data, rom_addr, block_x, block_y, hit_h, hit_v,
                 exp_pix[cyc], exp_addr[cyc], exp_bx[cyc], exp_by[cyc], exp_hh[cyc], exp_hv[cyc]);
      end
    end
  end

  initial begin
    int m0, c;
    rst_n = 1'b0; xpos = 0; ypos = 0; pause = 0;
    // Reset behaviour and the first pixels.
    repeat (3) cyc_drive(0, 0, 0);
    chk("t1_rst_pix", 32'(pixel_data), 32'h0);
    chk("t1_rst_bx", 32'(block_x), 32'd40);
    chk("t1_rst_addr", 32'(rom_addr), 32'd0);
    rst_n = 1'b1;
    m0 = cyc;
    cyc_drive(0, 0, 0);
    cyc_drive(40, 40, 0);
    cyc_drive(41, 40, 0);
    cyc_drive(40, 41, 0);
    cyc_drive(139, 139, 0);
    cyc_drive(39, 40, 0);
    cyc_drive(140, 140, 0);
    repeat (3) cyc_drive(600, 300, 0);
    chk("t1_border_lat3", 32'(obs_pix[m0+3]), 32'h0000FF);
    chk("t2_addr_40_40", 32'(obs_addr[m0+2]), 32'd0);
    chk("t5_key_transparent", 32'(obs_pix[m0+4]), 32'hFFFFFF);
    chk("t2_addr_41_40", 32'(obs_addr[m0+3]), 32'd1);
    chk("t5_green", 32'(obs_pix[m0+5]), 32'h00FF00);
    chk("t2_expand_8410", 32'(obs_pix[m0+6]), 32'h848284);
    chk("t2_addr_139_139", 32'(obs_addr[m0+5]), 32'd9999);
    chk("t2_red_lat3", 32'(obs_pix[m0+7]), 32'hFF0000);
    chk("t2_left_border", 32'(obs_pix[m0+8]), 32'h0000FF);
    chk("t2_outside_addr", 32'(obs_addr[m0+7]), 32'd0);
    chk("t2_background", 32'(obs_pix[m0+9]), 32'hFFFFFF);

    // Bounce sequence. The divider already holds 1 tick.
    for (int k = 1; k <= 159; k++) begin
      repeat ((k == 1) ? 1 : 2) frame(0);
      frame(0);
      c = cyc;
      if (k == 1) begin
        chk("t3_move1_x", 32'(obs_bx[c]), 32'd47);
        chk("t3_move1_y", 32'(obs_by[c]), 32'd47);
      end
      if (k == 78) begin
        chk("t3_ymax", 32'(obs_by[c]), 32'd580);
        chk("t3_hit_v_bottom", 32'(obs_hv[c]), 32'd1);
      end
      if (k == 156) begin
        chk("t3_ymin", 32'(obs_by[c]), 32'd40);
        chk("t3_hit_v_top", 32'(obs_hv[c]), 32'd1);
      end
      if (k == 157) chk("t3_x1139", 32'(obs_bx[c]), 32'd1139);
      if (k == 158) begin
        chk("t3_xmax_clamp", 32'(obs_bx[c]), 32'd1140);
        chk("t3_hit_h", 32'(obs_hh[c]), 32'd1);
      end
      if (k == 159) begin
        chk("t3_x_back", 32'(obs_bx[c]), 32'd1133);
        chk("t3_hit_h_clear", 32'(obs_hh[c]), 32'd0);
      end
      if (k % 40 == 0) begin
        // Random pixels, with the sprite and the border edges mixed in.
        for (int i = 0; i < 24; i++) begin
          case (i % 4)
            0: cyc_drive($urandom_range(1, 1279), $urandom_range(0, 719), 0);
            1: cyc_drive(mx + $urandom_range(0, 99), my + $urandom_range(0, 99), 0);
            2: cyc_drive(mx - 1 + 101 * (i % 2), my + (i % 100), 0);
            default: cyc_drive(1239 + (i % 3), 679 + (i % 3), 0);
          endcase
        end
      end
    end

    // Pause holds the position and the frame divider.
    repeat (5) frame(1);
    chk("t4_pause_hold_x", 32'(obs_bx[cyc]), 32'd1133);
    frame(0); frame(0);
    chk("t4_tick2_no_move", 32'(obs_bx[cyc]), 32'd1133);
    frame(0);
    chk("t4_tick3_move", 32'(obs_bx[cyc]), 32'd1126);
    frame(0);
    repeat (3) frame(1);
    frame(0);
    chk("t4_midcount_hold", 32'(obs_bx[cyc]), 32'd1126);
    frame(0);
    chk("t4_midcount_move", 32'(obs_bx[cyc]), 32'd1119);

    // Asynchronous reset in the middle of a line.
    xpos = 11'd600; ypos = 11'd300; pause = 0;
    model_eval();
    @(posedge clk);
    cyc++;
    #2 rst_n = 1'b0;
    exp_pix[cyc] = 24'h0; exp_addr[cyc] = 0; exp_bx[cyc] = SW; exp_by[cyc] = SW;
    exp_hh[cyc] = 0; exp_hv[cyc] = 0;
    #1;
    chk("t6_bx", 32'(block_x), 32'd40);
    chk("t6_by", 32'(block_y), 32'd40);
    chk("t6_pix", 32'(pixel_data), 32'h0);
    chk("t6_no_x", 32'($isunknown({pixel_data, rom_addr, block_x, block_y, hit_h, hit_v})), 32'd0);
    @(negedge clk);
    repeat (2) cyc_drive(600, 300, 0);
    rst_n = 1'b1;
    frame(0);
    chk("t6_after_tick1", 32'(obs_bx[cyc]), 32'd40);
    frame(0); frame(0);
    chk("t6_clean_move_x", 32'(obs_bx[cyc]), 32'd47);
    chk("t6_clean_move_y", 32'(obs_by[cyc]), 32'd47);
    cyc_drive(47, 47, 0);
    repeat (4) cyc_drive(600, 300, 0);
    chk("t6_sprite_origin_pix", 32'(obs_pix[cyc-2]), 32'hFFFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
